// File: rtl/rs_syndrome.sv
// Streaming Reed-Solomon syndrome calculator.
// Horner-accumulates S_j = r(alpha^(FCR+j)) per received symbol.

package gf_pkg;

  localparam int SYMB_WIDTH = 8;
  localparam int T_VAL      = 8;
  localparam int ROOTS_NUM  = 2 * T_VAL;
  localparam int GF_ORDER   = (1 << SYMB_WIDTH) - 1;

  localparam logic [SYMB_WIDTH:0] PRIM_POLY = 9'h11D;

  typedef logic [SYMB_WIDTH-1:0] symb_t;
  typedef symb_t [ROOTS_NUM-1:0] syn_t;

  // Shift-and-add multiply, reducing by the field polynomial each step
  function automatic symb_t gf_mult(
    input symb_t a,
    input symb_t b
  );
    symb_t p;
    symb_t x;
    p = '0;
    x = a;
    for (int i = 0; i < SYMB_WIDTH; i++) begin
      if (b[i])
        p = p ^ x;
      if (x[SYMB_WIDTH-1])
        x = (x << 1) ^ PRIM_POLY[SYMB_WIDTH-1:0];
      else
        x = x << 1;
    end
    return p;
  endfunction

  // alpha^e for any integer exponent
  function automatic symb_t gf_pow(input int e);
    symb_t r;
    int    n;
    r = symb_t'(1);
    n = e % GF_ORDER;
    if (n < 0)
      n = n + GF_ORDER;
    for (int i = 0; i < n; i++)
      r = gf_mult(r, symb_t'(2));
    return r;
  endfunction

  // Consecutive roots alpha^(fcr+j)
  function automatic syn_t gf_roots(input int fcr);
    syn_t r;
    for (int j = 0; j < ROOTS_NUM; j++)
      r[j] = gf_pow(fcr + j);
    return r;
  endfunction

endpackage

module rs_syndrome
  import gf_pkg::*;
#(
  parameter int N_LEN = 255,
  parameter int FCR   = 0
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [SYMB_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  output logic                  s_tready,
  output syn_t                  syndrome,
  output logic                  syndrome_vld,
  output logic                  syndrome_nonzero,
  output logic                  frame_err
);

  localparam int CW = $clog2(N_LEN);

  localparam logic [CW-1:0] LAST = CW'(N_LEN - 1);

  localparam syn_t ROOTS = gf_roots(FCR);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DROP
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  syn_t          acc;
  syn_t          acc_next;
  logic          beat;
  logic          acc_en;
  logic          syn_ld;
  logic          err_n;

  // Never back-pressure; only blocked while reset is held
  assign s_tready = ~areset;
  assign beat     = s_tvalid & s_tready;

  // Horner step; first beat of a frame starts from zero
  always_comb begin
    acc_next = '0;
    for (int j = 0; j < ROOTS_NUM; j++) begin
      if (state == IDLE)
        acc_next[j] = s_tdata;
      else
        acc_next[j] = gf_mult(acc[j], ROOTS[j]) ^ s_tdata;
    end
  end

  // Frame-length FSM: next state, counter and output strobes
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    acc_en  = 1'b0;
    syn_ld  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (beat) begin
          acc_en = 1'b1;
          if (s_tlast) begin
            err_n = 1'b1;
          end else begin
            state_n = ACCUM;
            cnt_n   = CW'(1);
          end
        end
      end
      ACCUM: begin
        if (beat) begin
          if (cnt == LAST) begin
            cnt_n = '0;
            if (s_tlast) begin
              acc_en  = 1'b1;
              syn_ld  = 1'b1;
              state_n = IDLE;
            end else begin
              state_n = DROP;
            end
          end else if (s_tlast) begin
            err_n   = 1'b1;
            cnt_n   = '0;
            state_n = IDLE;
          end else begin
            acc_en = 1'b1;
            cnt_n  = cnt + CW'(1);
          end
        end
      end
      DROP: begin
        if (beat && s_tlast) begin
          err_n   = 1'b1;
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // State and symbol counter
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Syndrome accumulators
  always_ff @(posedge aclk or posedge areset) begin
    if (areset)
      acc <= '0;
    else if (acc_en)
      acc <= acc_next;
  end

  // Registered syndrome vector and one-cycle strobes
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      syndrome         <= '0;
      syndrome_vld     <= 1'b0;
      syndrome_nonzero <= 1'b0;
      frame_err        <= 1'b0;
    end else begin
      syndrome_vld     <= syn_ld;
      syndrome_nonzero <= syn_ld & (|acc_next);
      frame_err        <= err_n;
      if (syn_ld)
        syndrome <= acc_next;
    end
  end

endmodule

// File: tb/tb_rs_syndrome.sv
// Self-checking bench for rs_syndrome.
// Expected outcomes are queued at tlast and checked when the DUT responds.

module tb_rs_syndrome;
  import gf_pkg::*;

  localparam int N   = 255;
  localparam int FCR = 0;

  typedef struct {
    bit   err;
    syn_t syn;
    bit   nz;
    int   cyc;
  } exp_t;

  typedef struct {
    string name;
    int    pos;
    symb_t val;
    int    len;
    bit    gaps;
    bit    err;
    bit    nz;
  } vec_t;

  logic  clk;
  logic  rst;
  symb_t s_tdata;
  logic  s_tvalid;
  logic  s_tlast;
  logic  s_tready;
  syn_t  syndrome;
  logic  syndrome_vld;
  logic  syndrome_nonzero;
  logic  frame_err;

  int    errors;
  int    checks;
  int    cyc;
  exp_t  q[$];
  exp_t  me;
  syn_t  hold;
  symb_t fbuf [0:299];
  symb_t gp   [0:16];
  symb_t cw   [0:254];
  vec_t  vt   [0:6];

  rs_syndrome #(
    .N_LEN(N),
    .FCR  (FCR)
  ) dut (
    .aclk            (clk),
    .areset          (rst),
    .s_tdata         (s_tdata),
    .s_tvalid        (s_tvalid),
    .s_tlast         (s_tlast),
    .s_tready        (s_tready),
    .syndrome        (syndrome),
    .syndrome_vld    (syndrome_vld),
    .syndrome_nonzero(syndrome_nonzero),
    .frame_err       (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(
    input bit           ok,
    input string        nm,
    input logic [127:0] act,
    input logic [127:0] req
  );
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Direct polynomial evaluation of the first len beats
  function automatic syn_t model(input int len);
    syn_t s;
    s = '0;
    for (int j = 0; j < ROOTS_NUM; j++)
      for (int i = 0; i < len; i++)
        if (fbuf[i] != '0)
          s[j] ^= gf_mult(fbuf[i], gf_pow((len - 1 - i) * (FCR + j)));
    return s;
  endfunction

  function automatic exp_t good(input syn_t s, input bit nz);
    exp_t e;
    e.err = 1'b0;
    e.syn = s;
    e.nz  = nz;
    e.cyc = 0;
    return e;
  endfunction

  function automatic exp_t bad();
    exp_t e;
    e.err = 1'b1;
    e.syn = hold;
    e.nz  = 1'b0;
    e.cyc = 0;
    return e;
  endfunction

  task automatic send(input int len, input bit gaps, input exp_t e);
    int g;
    for (int i = 0; i < len; i++) begin
      g = gaps ? int'($urandom_range(0, 2)) : 0;
      repeat (g) begin
        @(posedge clk);
        #1 s_tvalid = 1'b0;
        s_tlast = 1'b0;
      end
      @(posedge clk);
      #1;
      s_tvalid = 1'b1;
      s_tdata  = fbuf[i];
      s_tlast  = (i == len - 1);
      if (i == len - 1) begin
        e.cyc = cyc + 1;
        q.push_back(e);
        if (!e.err)
          hold = e.syn;
      end
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1 s_tvalid = 1'b0;
    s_tlast = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic clear_buf();
    for (int i = 0; i < 300; i++)
      fbuf[i] = '0;
  endtask

  task automatic rand_buf();
    for (int i = 0; i < 300; i++)
      fbuf[i] = symb_t'($urandom);
  endtask

  // Response checker
  always @(negedge clk) begin
    if (!rst && (syndrome_vld || frame_err)) begin
      check(!(syndrome_vld && frame_err), "vld_err_overlap",
            {syndrome_vld, frame_err}, 0);
      check(q.size() != 0, "unexpected_output",
            {syndrome_vld, frame_err}, 0);
      if (q.size() != 0) begin
        me = q.pop_front();
        check(frame_err == me.err, "kind", frame_err, me.err);
        check(cyc == me.cyc, "latency", cyc, me.cyc);
        check(syndrome == me.syn, "syndrome", syndrome, me.syn);
        check(syndrome_nonzero == me.nz, "nonzero",
              syndrome_nonzero, me.nz);
      end
    end
  end

  initial begin
    exp_t  e;
    symb_t r;
    symb_t m;
    symb_t ev;
    int    k;
    syn_t  s;

    errors   = 0;
    checks   = 0;
    cyc      = 0;
    hold     = '0;
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;

    vt[0] = '{"zeros",    0,   8'h00, 255, 1'b0, 1'b0, 1'b0};
    vt[1] = '{"last01",   254, 8'h01, 255, 1'b0, 1'b0, 1'b1};
    vt[2] = '{"first01",  0,   8'h01, 255, 1'b0, 1'b0, 1'b1};
    vt[3] = '{"mid_gaps", 77,  8'hA5, 255, 1'b1, 1'b0, 1'b1};
    vt[4] = '{"short100", 3,   8'h01, 100, 1'b0, 1'b1, 1'b0};
    vt[5] = '{"long256",  9,   8'h07, 256, 1'b1, 1'b1, 1'b0};
    vt[6] = '{"after_err",200, 8'h3C, 255, 1'b0, 1'b0, 1'b1};

    repeat (2) @(negedge clk);
    check(s_tready == 1'b0, "rst_tready", s_tready, 0);
    check(syndrome_vld == 1'b0, "rst_vld", syndrome_vld, 0);
    check(frame_err == 1'b0, "rst_err", frame_err, 0);
    check(syndrome_nonzero == 1'b0, "rst_nz", syndrome_nonzero, 0);
    check(syndrome == '0, "rst_syn", syndrome, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check(s_tready == 1'b1, "tready_after_rst", s_tready, 1);

    // Table-driven single-error frames
    for (int v = 0; v < 7; v++) begin
      clear_buf();
      fbuf[vt[v].pos] = vt[v].val;
      if (vt[v].err)
        e = bad();
      else
        e = good(model(vt[v].len), vt[v].nz);
      send(vt[v].len, vt[v].gaps, e);
      idle(3);
    end

    // Last beat 01 must give 01 in every syndrome
    for (int j = 0; j < ROOTS_NUM; j++)
      s[j] = 8'h01;
    clear_buf();
    fbuf[254] = 8'h01;
    send(N, 1'b0, good(s, 1'b1));
    idle(3);

    // Valid codeword g(x)*m(x) plus one error of value ev at degree k
    for (int i = 0; i < 17; i++)
      gp[i] = '0;
    gp[0] = 8'h01;
    for (int j = 0; j < ROOTS_NUM; j++) begin
      r = gf_pow(FCR + j);
      for (int i = j + 1; i > 0; i--)
        gp[i] = gp[i-1] ^ gf_mult(gp[i], r);
      gp[0] = gf_mult(gp[0], r);
    end
    for (int i = 0; i < 255; i++)
      cw[i] = '0;
    for (int a = 0; a < 239; a++) begin
      m = symb_t'($urandom);
      for (int b = 0; b < 17; b++)
        cw[a+b] ^= gf_mult(m, gp[b]);
    end
    k  = int'($urandom_range(0, 254));
    ev = 8'h5B;
    clear_buf();
    for (int i = 0; i < 255; i++)
      fbuf[i] = cw[254-i];
    fbuf[254-k] ^= ev;
    for (int j = 0; j < ROOTS_NUM; j++)
      s[j] = gf_mult(ev, gf_pow(k * (FCR + j)));
    send(N, 1'b0, good(s, 1'b1));
    idle(3);

    // Clean codeword: all syndromes zero
    for (int i = 0; i < 255; i++)
      fbuf[i] = cw[254-i];
    send(N, 1'b1, good('0, 1'b0));
    idle(3);

    // Back-to-back random frames with valid gaps
    rand_buf();
    send(N, 1'b1, good(model(N), 1'b1));
    rand_buf();
    send(N, 1'b1, good(model(N), 1'b1));
    rand_buf();
    send(N, 1'b0, good(model(N), 1'b1));
    idle(3);

    // Length-1 frame
    fbuf[0] = 8'h55;
    send(1, 1'b0, bad());
    idle(3);

    // Reset mid-frame: partial frame must vanish silently
    rand_buf();
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      s_tvalid = 1'b1;
      s_tdata  = fbuf[i];
      s_tlast  = 1'b0;
    end
    @(posedge clk);
    #1;
    rst      = 1'b1;
    s_tvalid = 1'b0;
    @(negedge clk);
    check(s_tready == 1'b0, "midrst_tready", s_tready, 0);
    check(syndrome == '0, "midrst_syn", syndrome, 0);
    hold = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    idle(20);

    // Recovery frame after reset
    clear_buf();
    fbuf[10] = 8'hC3;
    send(N, 1'b0, good(model(N), 1'b1));
    idle(3);

    for (int w = 0; w < 200 && q.size() > 0; w++)
      @(posedge clk);
    check(q.size() == 0, "drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
